// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM stage and its MEM/WB register.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // Register $zero: writes to it are architecturally discarded.
    localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack port: the stage is master, the memory is slave.
interface mem_wb_stage_if #(
    parameter int DATA_W = mem_wb_stage_pkg::DATA_W_DEF
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register; inserts a bubble (wb_valid=0) while stalled.
// Latency: 1 cycle from input to wb_* outputs.
// Backpressure: none of its own; holds rd/data and drops valid while stall=1.
module mem_wb_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              bus_err
);

    logic              wb_valid_d,     wb_valid_q;
    logic              wb_reg_write_d, wb_reg_write_q;
    logic [REG_W-1:0]  wb_rd_d,        wb_rd_q;
    logic [DATA_W-1:0] wb_data_d,      wb_data_q;
    logic              bus_err_d,      bus_err_q;

    always_comb begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        bus_err_d      = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        if (!stall) begin
            wb_valid_d     = in_valid;
            wb_reg_write_d = in_valid & in_reg_write & (in_rd != REG_W'(REG_ZERO));
            wb_rd_d        = in_rd;
            wb_data_d      = in_data;
            bus_err_d      = in_err;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            bus_err_q      <= 1'b0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign bus_err      = bus_err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory stage + MEM/WB register; MEM_ALIGN_CHECK_EN aborts misaligned accesses.
// Latency: ALU ops 1 cycle; memory ops 2 cycles best case, ack-dependent beyond.
// Backpressure: stall holds EX/MEM until dmem_ack or TIMEOUT abort releases it.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              stall,
    mem_wb_stage_if.master    dmem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e            state_d,     state_q;
    logic [CNT_W-1:0]  cnt_d,       cnt_q;
    logic              req_d,       req_q;
    logic              we_d,        we_q;
    logic [DATA_W-1:0] addr_d,      addr_q;
    logic [DATA_W-1:0] wdata_d,     wdata_q;
    logic [REG_W-1:0]  lat_rd_d,    lat_rd_q;
    logic              lat_rw_d,    lat_rw_q;
    logic              lat_m2r_d,   lat_m2r_q;

    logic              memop;
    logic              misalign;
    logic              timeout_hit;
    logic              stall_c;
    logic              wb_in_valid;
    logic              wb_in_rw;
    logic [REG_W-1:0]  wb_in_rd;
    logic [DATA_W-1:0] wb_in_data;
    logic              wb_in_err;

    assign memop       = ex_valid & (ex_mem_read | ex_mem_write);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = memop & (ex_alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_rd_d    = lat_rd_q;
        lat_rw_d    = lat_rw_q;
        lat_m2r_d   = lat_m2r_q;
        stall_c     = 1'b0;
        wb_in_valid = ex_valid;
        wb_in_rw    = ex_reg_write;
        wb_in_rd    = ex_rd;
        wb_in_data  = ex_alu_result;
        wb_in_err   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (misalign) begin
                    wb_in_valid = 1'b1;
                    wb_in_rw    = 1'b0;
                    wb_in_err   = 1'b1;
                end else if (memop) begin
                    stall_c   = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    // Load wins when both read and write are flagged.
                    we_d      = ~ex_mem_read;
                    addr_d    = ex_alu_result;
                    wdata_d   = ex_store_data;
                    lat_rd_d  = ex_rd;
                    lat_rw_d  = ex_reg_write & ex_mem_read;
                    lat_m2r_d = ex_mem_to_reg;
                end
            end
            ST_WAIT: begin
                wb_in_valid = 1'b1;
                wb_in_rd    = lat_rd_q;
                wb_in_data  = addr_q;
                wb_in_rw    = 1'b0;
                if (dmem.dmem_ack) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_in_rw   = lat_rw_q;
                    wb_in_data = lat_m2r_q ? dmem.dmem_rdata : addr_q;
                end else if (timeout_hit) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    wb_in_err = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_rd_q  <= '0;
            lat_rw_q  <= 1'b0;
            lat_m2r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_rd_q  <= lat_rd_d;
            lat_rw_q  <= lat_rw_d;
            lat_m2r_q <= lat_m2r_d;
        end
    end

    // Upstream is never held while the core is in reset.
    assign stall           = stall_c & Reset;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .Clk          (Clk),
        .Reset        (Reset),
        .stall        (stall_c),
        .in_valid     (wb_in_valid),
        .in_reg_write (wb_in_rw),
        .in_rd        (wb_in_rd),
        .in_data      (wb_in_data),
        .in_err       (wb_in_err),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .bus_err      (bus_err)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage; the bench also plays the data memory.
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, wb_reg_write, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_wb_stage_if #(.DATA_W(32)) dmem_if ();

    mem_wb_stage #(
        .DATA_W  (32),
        .REG_W   (5),
        .TIMEOUT (TO)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .stall         (stall),
        .dmem          (dmem_if),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .bus_err       (bus_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic        err;
        logic        chk;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Writeback monitor: every valid slot must match the oldest expectation.
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.wr});
                    check("wb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    if (e.chk) begin
                        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                        check("wb_data", wb_data, e.data);
                    end
                end
            end else if (wb_reg_write || bus_err) begin
                check("idle_slot_quiet", {30'd0, wb_reg_write, bus_err}, 32'd0);
            end
        end
    end

    // Issues one EX/MEM slot starting just after a rising edge; returns just after a rising edge.
    task automatic do_instr(input logic v, input logic rw, input logic mr, input logic mw,
                            input logic m2r, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] rd, input int delay, input logic [31:0] rdata);
        exp_t e;
        logic memop, mis, done;
        ex_valid      = v;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_mem_to_reg = m2r;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = rd;
        memop = v & (mr | mw);
        mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = memop && (alu[1:0] != 2'b00);
`endif
        if (!memop || mis) begin
            if (v) begin
                e.err  = mis;
                e.wr   = !mis && rw && (rd != 5'd0);
                e.chk  = !mis;
                e.rd   = rd;
                e.data = alu;
                exp_q.push_back(e);
            end
            // A stray ack outside a request must be ignored.
            dmem_if.dmem_ack = 1'($urandom_range(0, 1));
            @(negedge Clk);
            check("stall_no_memop", {31'd0, stall}, 32'd0);
            check("req_no_memop", {31'd0, dmem_if.dmem_req}, 32'd0);
            @(posedge Clk);
            #1;
            dmem_if.dmem_ack = 1'b0;
        end else begin
            @(negedge Clk);
            check("stall_issue", {31'd0, stall}, 32'd1);
            check("req_issue", {31'd0, dmem_if.dmem_req}, 32'd0);
            @(posedge Clk);
            #1;
            for (int k = 0; k < TO; k++) begin
                dmem_if.dmem_ack   = (k == delay);
                dmem_if.dmem_rdata = rdata;
                done = (k == delay) || (k == TO - 1);
                if (done) begin
                    if (k == delay) begin
                        e.err  = 1'b0;
                        e.wr   = mr && rw && (rd != 5'd0);
                        e.chk  = 1'b1;
                        e.rd   = rd;
                        e.data = m2r ? rdata : alu;
                    end else begin
                        e.err  = 1'b1;
                        e.wr   = 1'b0;
                        e.chk  = 1'b0;
                        e.rd   = rd;
                        e.data = 32'd0;
                    end
                    exp_q.push_back(e);
                end
                @(negedge Clk);
                check("req_wait", {31'd0, dmem_if.dmem_req}, 32'd1);
                check("addr_wait", dmem_if.dmem_addr, alu);
                check("we_wait", {31'd0, dmem_if.dmem_we}, {31'd0, !mr});
                if (!mr) check("wdata_wait", dmem_if.dmem_wdata, sd);
                check("stall_wait", {31'd0, stall}, {31'd0, !done});
                @(posedge Clk);
                #1;
                dmem_if.dmem_ack = 1'b0;
                if (done) break;
            end
        end
    endtask

    initial begin
        repeat (50000) @(posedge Clk);
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_mem_to_reg = 1'b0; ex_alu_result = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0;
        dmem_if.dmem_ack = 1'b0;
        dmem_if.dmem_rdata = 32'd0;

        repeat (2) @(negedge Clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_if.dmem_we}, 32'd0);
        check("rst_addr", dmem_if.dmem_addr, 32'd0);
        check("rst_wdata", dmem_if.dmem_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;

        // Directed cases
        do_instr(1, 1, 0, 0, 0, 32'h0000_1234, 32'd0, 5'd8, 0, 32'd0);
        do_instr(1, 1, 1, 0, 1, 32'h0000_0040, 32'd0, 5'd5, 3, 32'hDEAD_BEEF);
        do_instr(1, 0, 0, 1, 0, 32'h0000_0080, 32'h55, 5'd0, 0, 32'd0);
        do_instr(1, 1, 1, 0, 1, 32'h0000_0100, 32'd0, 5'd9, 99, 32'd0);
        do_instr(1, 1, 0, 0, 0, 32'h0000_7777, 32'd0, 5'd0, 0, 32'd0);
        do_instr(1, 1, 1, 0, 1, 32'h0000_0042, 32'd0, 5'd7, 1, 32'hCAFE_F00D);
        do_instr(1, 1, 1, 1, 1, 32'h0000_0044, 32'h99, 5'd6, 0, 32'h1357_9BDF);
        do_instr(0, 1, 1, 0, 1, 32'h0000_0048, 32'd0, 5'd4, 0, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          kind;
            logic        v, mr, mw;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            v    = ($urandom_range(0, 9) != 0);
            mr   = (kind >= 4 && kind <= 6) || kind == 9;
            mw   = (kind >= 7);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0 && (mr || mw)) a[1:0] = 2'b00;
            do_instr(v, 1'($urandom_range(0, 1)), mr, mw, 1'($urandom_range(0, 1)), a,
                     $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, TO + 1), $urandom);
        end

        // Reset asserted while a load is waiting for its ack
        ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_mem_to_reg = 1'b1; ex_alu_result = 32'h0000_0200; ex_rd = 5'd3;
        repeat (3) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("rstwait_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        check("rstwait_stall", {31'd0, stall}, 32'd0);
        check("rstwait_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rstwait_bus_err", {31'd0, bus_err}, 32'd0);
        ex_valid = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        do_instr(1, 1, 0, 0, 0, 32'h0000_ABCD, 32'd0, 5'd3, 0, 32'd0);
        do_instr(1, 1, 1, 0, 1, 32'h0000_0204, 32'd0, 5'd12, 0, 32'h0BAD_F00D);
        ex_valid = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
